// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix-vector sequencer.
package matrix_pkg;

    localparam int unsigned DATA_SIZE_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCalc,
        StEmit,
        StDone
    } state_e;

    // Upper accumulator bits (zero-extended); any set bit means the result saturates.
    function automatic logic acc_overflows(input logic [63:0] upper_bits);
        return |upper_bits;
    endfunction

endpackage

// File: rtl/matrix_seq_dot.sv
// Combinational dot product of one A vector with one B column, upper-half products, saturating.
module matrix_seq_dot
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned VEC_LEN   = 16
) (
    input  logic [DATA_SIZE*VEC_LEN-1:0] a_vec,
    input  logic [DATA_SIZE*VEC_LEN-1:0] b_vec,
    output logic [DATA_SIZE-1:0]         result
);

    localparam int unsigned PROD_W = 2 * DATA_SIZE;
    localparam int unsigned ACC_W  = DATA_SIZE + $clog2(VEC_LEN);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            prod = PROD_W'(a_vec[i*DATA_SIZE +: DATA_SIZE]) *
                   PROD_W'(b_vec[i*DATA_SIZE +: DATA_SIZE]);
            acc  = acc + ACC_W'(prod[PROD_W-1:DATA_SIZE]);
        end
        result = acc_overflows(64'(acc >> DATA_SIZE)) ? '1 : acc[DATA_SIZE-1:0];
    end

endmodule

// File: rtl/matrix_seq.sv
// Column-sequenced matrix-vector product with a valid/ready result stream.
// Optional cycle counter output perf_cycles enabled by defining MATRIX_SEQ_PERF_EN.
module matrix_seq
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned VEC_LEN   = 16,
    parameter int unsigned OUT_LEN   = 16,
    localparam int unsigned IDX_W    = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DATA_SIZE*VEC_LEN-1:0] a_vec,
    output logic                         b_rd_en,
    output logic [IDX_W-1:0]             b_addr,
    input  logic [DATA_SIZE*VEC_LEN-1:0] b_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_SIZE-1:0]         out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         busy,
`ifdef MATRIX_SEQ_PERF_EN
    output logic [31:0]                  perf_cycles,
`endif
    output logic                         done
);

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(OUT_LEN - 1);

    state_e                       state_q;
    logic [IDX_W-1:0]             col_q;
    logic [DATA_SIZE*VEC_LEN-1:0] a_q;
    logic [DATA_SIZE-1:0]         dot_result;

    matrix_seq_dot #(
        .DATA_SIZE(DATA_SIZE),
        .VEC_LEN  (VEC_LEN)
    ) u_dot (
        .a_vec (a_q),
        .b_vec (b_rdata),
        .result(dot_result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            col_q     <= '0;
            a_q       <= '0;
            b_rd_en   <= 1'b0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            b_rd_en <= 1'b0;
            done    <= 1'b0;
            // Abort wins over everything, including a handshake in the same cycle.
            if (abort && state_q != StIdle) begin
                state_q   <= StIdle;
                col_q     <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            a_q     <= a_vec;
                            col_q   <= '0;
                            b_addr  <= '0;
                            b_rd_en <= 1'b1;
                            busy    <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                    StFetch: state_q <= StCalc;
                    StCalc: begin
                        out_data  <= dot_result;
                        out_idx   <= col_q;
                        out_valid <= 1'b1;
                        state_q   <= StEmit;
                    end
                    StEmit: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (col_q == LAST_COL) begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                col_q   <= col_q + IDX_W'(1);
                                b_addr  <= col_q + IDX_W'(1);
                                b_rd_en <= 1'b1;
                                state_q <= StFetch;
                            end
                        end
                    end
                    StDone: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

`ifdef MATRIX_SEQ_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (state_q == StIdle) begin
            if (start && !abort) perf_cycles <= '0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_seq.sv
// Directed bench for matrix_seq with a behavioural dot-product model and a per-cycle monitor.
module tb_matrix_seq;

    localparam int DS = 8;
    localparam int VL = 4;
    localparam int OL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [31:0]   a_vec;
    logic          b_rd_en;
    logic [1:0]    b_addr;
    logic [31:0]   b_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [1:0]    out_idx;
    logic          busy;
    logic          done;
`ifdef MATRIX_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    matrix_seq #(
        .DATA_SIZE(DS),
        .VEC_LEN  (VL),
        .OUT_LEN  (OL)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .a_vec    (a_vec),
        .b_rd_en  (b_rd_en),
        .b_addr   (b_addr),
        .b_rdata  (b_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
`ifdef MATRIX_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .done     (done)
    );

    always #5 clock = ~clock;

    // Column storage with one-cycle read latency.
    logic [31:0] mem [OL];
    always @(posedge clock) if (b_rd_en) b_rdata <= mem[b_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Element i sits at bits [8i+7:8i]; product upper byte, summed, clipped at 255.
    function automatic int model_dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < VL; i++) s += (int'(a[i*8 +: 8]) * int'(b[i*8 +: 8])) / 256;
        return (s > 255) ? 255 : s;
    endfunction

    int  exp_idx[$];
    int  exp_dat[$];
    int  xfer_cnt;
    int  got_data[OL];
    bit  held = 0;
    logic [7:0] held_data;
    logic [1:0] held_idx;

    // Compare process: every handshake against the model, stability while stalled.
    always @(negedge clock) begin
        if (!reset) begin
            held = 0;
        end else begin
            if (b_rd_en && out_valid) check("rd_en_during_emit", {b_rd_en, out_valid}, 2'b01);
            if (out_valid) begin
                if (held) begin
                    check("hold_data", out_data, held_data);
                    check("hold_idx", out_idx, held_idx);
                end
                if (out_ready) begin
                    xfer_cnt++;
                    got_data[out_idx] = out_data;
                    held = 0;
                    check("xfer_expected", exp_idx.size() > 0, 1);
                    if (exp_idx.size() > 0) begin
                        check("out_idx", out_idx, exp_idx.pop_front());
                        check("out_data", out_data, exp_dat.pop_front());
                    end
                end else begin
                    held = 1;
                    held_data = out_data;
                    held_idx = out_idx;
                end
            end else begin
                held = 0;
            end
        end
    end

    int hs_cyc[OL];
    int done_cyc;
    int done_cnt;

    task automatic run_job(input logic [31:0] a, input int stall_idx, input int stall_len,
                           input int abort_col, input bit start_in_emit);
        int cyc;
        int stall_n = 0;
        int abort_at = -1;
        bit stop = 0;
        for (int k = 0; k < OL; k++) begin
            exp_idx.push_back(k);
            exp_dat.push_back(model_dot(a, mem[k]));
            hs_cyc[k] = -1;
        end
        xfer_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        a_vec = a;
        start = 1;
        out_ready = 1;
        @(posedge clock); #1;
        start = 0;
        a_vec = ~a;
        cyc = 1;
        check("fetch0_rd_en", b_rd_en, 1);
        check("fetch0_addr", b_addr, 0);
        while (cyc < 200 && !stop) begin
            out_ready = 1;
            abort = 0;
            start = 0;
            if (out_valid && hs_cyc[out_idx] < 0) hs_cyc[out_idx] = cyc;
            if (out_valid && int'(out_idx) == stall_idx && stall_n < stall_len) begin
                out_ready = 0;
                stall_n++;
                check("stall_no_rd_en", b_rd_en, 0);
            end
            if (start_in_emit && out_valid && out_idx == 2'd0) start = 1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (abort_col >= 0 && b_rd_en && int'(b_addr) == abort_col) abort_at = cyc + 1;
            if (cyc == abort_at) abort = 1;
            if (cyc == abort_at + 1) begin
                check("abort_busy", busy, 0);
                check("abort_valid", out_valid, 0);
                exp_idx.delete();
                exp_dat.delete();
            end
            if (!busy) stop = 1;
            if (!stop) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check("job_terminates", stop, 1);
        abort = 0;
        start = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        start = 0;
        abort = 0;
        out_ready = 0;
        a_vec = '0;
        for (int k = 0; k < OL; k++) mem[k] = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rd_en", b_rd_en, 0);
        check("rst_addr", b_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1;
        @(posedge clock); #1;

        // Pin the model against hand-computed values.
        check("model_10x10", model_dot(32'h10101010, 32'h10101010), 8'h04);
        check("model_ffxff", model_dot(32'hFFFFFFFF, 32'hFFFFFFFF), 8'hFF);
        check("model_desc", model_dot(32'h10204080, 32'hFFFFFFFF), 8'hEC);
        check("model_0x100", model_dot(32'h80808080, 32'h80808080), 8'hFF);
        check("model_0xfe", model_dot(32'h80808080, 32'h7C808080), 8'hFE);

        // Nominal timing with all 0x10.
        for (int k = 0; k < OL; k++) mem[k] = 32'h10101010;
        run_job(32'h10101010, -1, 0, -1, 0);
        for (int k = 0; k < OL; k++) begin
            check("t1_present_cycle", hs_cyc[k], 3 + 3 * k);
            check("t1_data", got_data[k], 8'h04);
        end
        check("t1_done_cycle", done_cyc, 13);
        check("t1_done_count", done_cnt, 1);
        check("t1_xfers", xfer_cnt, 4);
        check("t1_queue_empty", exp_idx.size(), 0);
`ifdef MATRIX_SEQ_PERF_EN
        check("t1_perf", perf_cycles, 13);
`endif

        // Full saturation.
        for (int k = 0; k < OL; k++) mem[k] = 32'hFFFFFFFF;
        run_job(32'hFFFFFFFF, -1, 0, -1, 0);
        for (int k = 0; k < OL; k++) check("t2_sat", got_data[k], 8'hFF);
        check("t2_xfers", xfer_cnt, 4);

        // Saturation boundary, 5-cycle stall on col 1, start pulsed during EMIT.
        mem[0] = 32'h80808080;
        mem[1] = 32'h7C808080;
        mem[2] = 32'h00000000;
        mem[3] = 32'h08060402;
        run_job(32'h80808080, 1, 5, -1, 1);
        check("t3_col0", got_data[0], 8'hFF);
        check("t3_col1", got_data[1], 8'hFE);
        check("t3_col2", got_data[2], 8'h00);
        check("t3_col3", got_data[3], 8'h0A);
        check("t3_col1_cycle", hs_cyc[1], 6);
        check("t3_col2_cycle", hs_cyc[2], 14);
        check("t3_done_cycle", done_cyc, 18);
        check("t3_xfers", xfer_cnt, 4);

        // Abort in CALC of col 2, then a clean job.
        run_job(32'h10204080, -1, 0, 2, 0);
        check("t4_no_done", done_cnt, 0);
        check("t4_xfers", xfer_cnt, 2);
        run_job(32'hFFFFFFFF, -1, 0, -1, 0);
        check("t4_restart_done", done_cyc, 13);
        check("t4_restart_xfers", xfer_cnt, 4);
        check("t4_restart_col3", got_data[3], 8'h10);

        // Asynchronous reset during FETCH.
        a_vec = 32'h01020304;
        start = 1;
        @(posedge clock); #1;
        start = 0;
        check("t5_fetch", b_rd_en, 1);
        reset = 0;
        #1;
        check("t5_rd_en", b_rd_en, 0);
        check("t5_data", out_data, 0);
        check("t5_idx", out_idx, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", out_valid, 0);
        check("t5_done", done, 0);
        @(posedge clock); #1;
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check("t5_idle_busy", busy, 0);
            check("t5_idle_rd_en", b_rd_en, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_seq.md
MATRIX_SEQ -- requirements
Module: matrix_seq

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, element width in bits.
REQ-002 SHALL have parameter VEC_LEN, default 16, elements per input vector and per matrix column.
REQ-003 SHALL have parameter OUT_LEN, default 16, number of matrix columns (output elements).
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  job request; sampled only in IDLE.
REQ-007 SHALL have port abort  in  1  synchronous job cancel.
REQ-008 SHALL have port a_vec  in  DATA_SIZE*VEC_LEN  vector A; latched on accepted start.
REQ-009 SHALL have port b_rd_en  out  1  column read strobe to matrix storage.
REQ-010 SHALL have port b_addr  out  clog2(OUT_LEN)  column index being read.
REQ-011 SHALL have port b_rdata  in  DATA_SIZE*VEC_LEN  column data; valid exactly one cycle after b_rd_en.
REQ-012 SHALL have port out_valid  out  1  result element valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.
REQ-014 SHALL have port out_data  out  DATA_SIZE  result element.
REQ-015 SHALL have port out_idx  out  clog2(OUT_LEN)  column index of out_data.
REQ-016 SHALL have ports busy and done  out  1 each: busy high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, CALC, EMIT, DONE.
REQ-018 IDLE: start=1 -> latch a_vec, col=0, go FETCH; otherwise stay.
REQ-019 FETCH: b_rd_en=1, b_addr=col for exactly one cycle; go CALC.
REQ-020 CALC: per element p_i = (a_i*b_i)[2*DATA_SIZE-1:DATA_SIZE] (unsigned, upper half); sum all p_i in a DATA_SIZE+clog2(VEC_LEN) accumulator; register the result; go EMIT.
REQ-021 Result SHALL saturate to all ones when any accumulator bit at or above DATA_SIZE is set; otherwise it equals the low DATA_SIZE bits.
REQ-022 EMIT: out_valid=1; out_data and out_idx held stable until out_valid&&out_ready; then go FETCH with col+1, or go DONE if col==OUT_LEN-1.
REQ-023 DONE: done=1 for one cycle; go IDLE.
REQ-024 Timing: start accepted at edge 0 -> b_rd_en at cycle 1, out_valid at cycle 3; with out_ready held 1, column k is presented at cycle 3+3k and done is at cycle 3*OUT_LEN+1.
REQ-025 abort=1 in any non-IDLE state -> IDLE on next edge; out_valid drops; no done pulse; abort takes priority over a simultaneous handshake.
REQ-026 start while busy SHALL be ignored; start and abort together in IDLE -> stay IDLE.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, col=0, and all outputs to 0, including mid-job; no done pulse; the job is lost.

Configuration
REQ-028 With MATRIX_SEQ_PERF_EN defined: SHALL add output perf_cycles (32 bits), cleared on accepted start, incremented every busy cycle, held after DONE/abort; without the macro: port and counter absent, all other behaviour identical.

Structure
REQ-029 Package matrix_pkg SHALL hold the state enum, DATA_SIZE default, and the saturation helper/constant.
REQ-030 Dot-product arithmetic (REQ-020/021) SHALL be the combinational sub-module matrix_seq_dot; the FSM and registers stay in matrix_seq.

Verification (DATA_SIZE=8, VEC_LEN=4, OUT_LEN=4; storage model with 1-cycle latency)
REQ-031 A all 0x10, B all 0x10, out_ready=1 -> four outputs 0x04 with idx 0..3 at cycles 3,6,9,12; done at cycle 13.
REQ-032 A all 0xFF, B all 0xFF -> each p_i=0xFE, sum 0x3F8 -> out_data 0xFF (saturated).
REQ-033 out_ready low 5 cycles during EMIT of col 1 -> out_valid, out_data, out_idx stable for all 5 cycles; no b_rd_en during that time; one transfer per handshake.
REQ-034 abort asserted in CALC of col 2 -> IDLE next cycle, busy=0, no done; new start then completes normally.
REQ-035 start pulsed during EMIT -> ignored; reset low during FETCH -> all outputs 0 immediately, FSM in IDLE.
